// File: rtl/sine_voice_bank.sv
// sine_voice_bank: multi-voice phase-accumulator sine synthesiser.
// On each sample strobe the voices are swept one per cycle through a shared
// sine table; the offset-binary amplitudes are summed and presented as one
// mixed sample. Voice configuration may only be written while idle.
module sine_voice_bank #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 32,
    parameter int LUT_ADDR_W = 6,   // must be at least 2 (quarter-wave table build)
    parameter int AMP_W      = 8,
    parameter int VID_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    parameter int SUM_W      = AMP_W + $clog2(NUM_VOICES)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic               cfg_valid_in,
    output logic               cfg_ready_out,
    input  logic [VID_W-1:0]   cfg_voice_in,
    input  logic               cfg_enable_in,
    input  logic [PHASE_W-1:0] cfg_incr_in,
    input  logic               cfg_load_phase_in,
    input  logic [PHASE_W-1:0] cfg_phase_in,
    output logic               busy_out,
    output logic [SUM_W-1:0]   sample_out,
    output logic               sample_valid_out,
    output logic               overrun_out
);

    localparam int LUT_N   = 2 ** LUT_ADDR_W;
    localparam int QUARTER = LUT_N / 4;
    localparam real PI     = 3.14159265358979323846;
    localparam logic [AMP_W-1:0] MIDSCALE = {1'b1, {(AMP_W-1){1'b0}}};

    typedef logic [LUT_N-1:0][AMP_W-1:0] lut_t;
    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_OUT} state_t;

    // sin(2*pi*m/LUT_N) for m in [0, QUARTER]; the series is exact at m=0,
    // so table entries at 0 and pi come out exactly midscale.
    function automatic real quarter_sin(input int m);
        real x;
        real term;
        real acc;
        x    = 2.0 * PI * $itor(m) / $itor(LUT_N);
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / $itor((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Full-cycle table built from quarter-wave symmetry, rounded to nearest.
    function automatic lut_t build_lut();
        lut_t t;
        real  s;
        real  v;
        int   q;
        int   r;
        for (int k = 0; k < LUT_N; k++) begin
            q = k / QUARTER;
            r = k % QUARTER;
            case (q)
                0:       s =  quarter_sin(r);
                1:       s =  quarter_sin(QUARTER - r);
                2:       s = -quarter_sin(r);
                default: s = -quarter_sin(QUARTER - r);
            endcase
            v    = ($itor(2 ** (AMP_W - 1)) - 0.5) * (1.0 + s) + 0.5;
            t[k] = AMP_W'($rtoi(v));
        end
        return t;
    endfunction

    localparam lut_t LUT = build_lut();

    state_t state, state_next;

    logic [VID_W-1:0]      vidx;
    logic                  drain_cnt;
    logic                  last_voice;
    logic                  step_accept;
    logic                  cfg_write;
    logic [31:0]           cfg_voice_ext;

    logic [PHASE_W-1:0]    phase  [NUM_VOICES];
    logic [PHASE_W-1:0]    incr   [NUM_VOICES];
    logic                  enable [NUM_VOICES];

    logic                  s0_valid;
    logic                  s0_en;
    logic [LUT_ADDR_W-1:0] s0_idx;
    logic                  s1_valid;
    logic [AMP_W-1:0]      s1_amp;
    logic [SUM_W-1:0]      acc;

    assign last_voice    = (vidx == VID_W'(NUM_VOICES - 1));
    assign cfg_voice_ext = 32'(cfg_voice_in);
    assign cfg_write     = cfg_valid_in && cfg_ready_out && (cfg_voice_ext < 32'(NUM_VOICES));
    assign step_accept   = step_in && !busy_out;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic: sweep every voice, drain two pipeline stages, publish.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (step_accept) state_next = S_SWEEP;
            S_SWEEP: if (last_voice) state_next = S_DRAIN;
            S_DRAIN: if (drain_cnt) state_next = S_OUT;
            S_OUT:   state_next = step_accept ? S_SWEEP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: busy while voices are being read or the pipeline drains.
    always_comb begin
        busy_out      = (state == S_SWEEP) || (state == S_DRAIN);
        cfg_ready_out = !busy_out;
    end

    // Sweep bookkeeping: voice index and drain-cycle counter.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vidx      <= '0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN);
            if (step_accept)             vidx <= '0;
            else if (state == S_SWEEP)   vidx <= vidx + 1'b1;
        end
    end

    // Voice state: config writes while idle, phase advance and stage-0 capture while sweeping.
    // NOTE: the small voice register file is reset because a reset must clear all voice config.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i]  <= '0;
                incr[i]   <= '0;
                enable[i] <= 1'b0;
            end
            s0_valid <= 1'b0;
            s0_en    <= 1'b0;
            s0_idx   <= '0;
        end else begin
            s0_valid <= (state == S_SWEEP);
            if (state == S_SWEEP) begin
                s0_idx <= phase[vidx][PHASE_W-1 -: LUT_ADDR_W];
                s0_en  <= enable[vidx];
                if (enable[vidx]) phase[vidx] <= phase[vidx] + incr[vidx];
            end
            if (cfg_write) begin
                enable[cfg_voice_in] <= cfg_enable_in;
                incr[cfg_voice_in]   <= cfg_incr_in;
                if (cfg_load_phase_in) phase[cfg_voice_in] <= cfg_phase_in;
            end
        end
    end

    // Stages 1-2: table lookup (disabled voices give midscale) and accumulation.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid <= 1'b0;
            s1_amp   <= '0;
            acc      <= '0;
        end else begin
            s1_valid <= s0_valid;
            s1_amp   <= s0_en ? LUT[s0_idx] : MIDSCALE;
            if (step_accept)   acc <= '0;
            else if (s1_valid) acc <= acc + SUM_W'(s1_amp);
        end
    end

    // Output register: publish the mix, pulse valid, record dropped strobes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            overrun_out      <= 1'b0;
        end else begin
            sample_valid_out <= (state == S_OUT);
            if (state == S_OUT)       sample_out  <= acc;
            if (step_in && busy_out)  overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sine_voice_bank.sv
// Directed testbench for sine_voice_bank with the default 4-voice configuration.
module tb_sine_voice_bank;

    localparam int NV = 4;
    localparam int PW = 32;
    localparam int VW = 2;
    localparam int SW = 10;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          step_in = 1'b0;
    logic          cfg_valid_in = 1'b0;
    logic          cfg_ready_out;
    logic [VW-1:0] cfg_voice_in = '0;
    logic          cfg_enable_in = 1'b0;
    logic [PW-1:0] cfg_incr_in = '0;
    logic          cfg_load_phase_in = 1'b0;
    logic [PW-1:0] cfg_phase_in = '0;
    logic          busy_out;
    logic [SW-1:0] sample_out;
    logic          sample_valid_out;
    logic          overrun_out;

    int checks = 0;
    int errors = 0;

    sine_voice_bank #(
        .NUM_VOICES(NV), .PHASE_W(PW), .LUT_ADDR_W(6), .AMP_W(8)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .step_in(step_in),
        .cfg_valid_in(cfg_valid_in),
        .cfg_ready_out(cfg_ready_out),
        .cfg_voice_in(cfg_voice_in),
        .cfg_enable_in(cfg_enable_in),
        .cfg_incr_in(cfg_incr_in),
        .cfg_load_phase_in(cfg_load_phase_in),
        .cfg_phase_in(cfg_phase_in),
        .busy_out(busy_out),
        .sample_out(sample_out),
        .sample_valid_out(sample_valid_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int v, input logic en, input logic [PW-1:0] inc,
                             input logic load, input logic [PW-1:0] ph);
        @(negedge clk_in);
        cfg_valid_in      = 1'b1;
        cfg_voice_in      = VW'(v);
        cfg_enable_in     = en;
        cfg_incr_in       = inc;
        cfg_load_phase_in = load;
        cfg_phase_in      = ph;
        @(posedge clk_in);
        #1 cfg_valid_in = 1'b0;
    endtask

    // Issue one strobe and wait (bounded) for the valid pulse.
    task automatic strobe(output logic [31:0] smp, output int lat, output int busy_cyc,
                          output logic found);
        smp = '0;
        found = 1'b0;
        lat = 0;
        @(negedge clk_in);
        step_in = 1'b1;
        @(posedge clk_in);
        #1 step_in = 1'b0;
        busy_cyc = busy_out ? 1 : 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (sample_valid_out) begin
                found = 1'b1;
                smp = 32'(sample_out);
            end else if (busy_out) begin
                busy_cyc++;
            end
        end
    endtask

    logic [31:0] smp;
    int          lat;
    int          bcyc;
    logic        found;
    int          pulses;
    logic [31:0] exp_v;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_sample", 32'(sample_out), 0);
        check("rst_valid", 32'(sample_valid_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_ready", 32'(cfg_ready_out), 1);
        check("rst_overrun", 32'(overrun_out), 0);
        rst_in = 1'b1;

        // 1: silence, latency and busy length
        strobe(smp, lat, bcyc, found);
        check("t1_found", 32'(found), 1);
        check("t1_latency", 32'(lat), 7);
        check("t1_busy_cycles", 32'(bcyc), 6);
        check("t1_sample", smp, 512);
        @(posedge clk_in);
        #1;
        check("t1_pulse_width", 32'(sample_valid_out), 0);
        check("t1_hold", 32'(sample_out), 512);
        check("t1_overrun", 32'(overrun_out), 0);

        // 2: voice0 sweeps the table one entry per strobe
        cfg_write(0, 1'b1, 32'h0400_0000, 1'b1, 32'h0);
        for (int s = 0; s <= 64; s++) begin
            strobe(smp, lat, bcyc, found);
            exp_v = 32'hFFFF_FFFF;
            case (s)
                0:  exp_v = 512;
                1:  exp_v = 524;
                2:  exp_v = 536;
                3:  exp_v = 549;
                16: exp_v = 639;
                32: exp_v = 512;
                48: exp_v = 384;
                63: exp_v = 499;
                64: exp_v = 512;
                default: ;
            endcase
            if (exp_v != 32'hFFFF_FFFF) begin
                check($sformatf("t2_step%0d", s), found ? smp : 32'hDEAD, exp_v);
            end
        end

        // 3: voice2 at peak, then disabled, then re-enabled without reload
        cfg_write(0, 1'b0, 32'h0, 1'b0, 32'h0);
        cfg_write(2, 1'b1, 32'h0, 1'b1, 32'h4000_0000);
        strobe(smp, lat, bcyc, found);
        check("t3_peak", smp, 639);
        strobe(smp, lat, bcyc, found);
        check("t3_peak_again", smp, 639);
        cfg_write(2, 1'b0, 32'h0, 1'b0, 32'h0);
        strobe(smp, lat, bcyc, found);
        check("t3_disabled", smp, 512);
        cfg_write(2, 1'b1, 32'h0, 1'b0, 32'h0);
        strobe(smp, lat, bcyc, found);
        check("t3_phase_kept", smp, 639);

        // 4: all voices at peak, then all at trough
        for (int v = 0; v < NV; v++) cfg_write(v, 1'b1, 32'h0, 1'b1, 32'h4000_0000);
        strobe(smp, lat, bcyc, found);
        check("t4_max", smp, 1020);
        for (int v = 0; v < NV; v++) cfg_write(v, 1'b1, 32'h0, 1'b1, 32'hC000_0000);
        strobe(smp, lat, bcyc, found);
        check("t4_min", smp, 0);

        // 5: config write and strobe during a sweep are both refused
        @(negedge clk_in);
        step_in = 1'b1;
        @(posedge clk_in);
        #1 step_in = 1'b0;
        @(negedge clk_in);
        cfg_valid_in      = 1'b1;
        cfg_voice_in      = 2'd0;
        cfg_enable_in     = 1'b0;
        cfg_load_phase_in = 1'b1;
        cfg_phase_in      = 32'h0;
        step_in           = 1'b1;
        #1;
        check("t5_ready_low", 32'(cfg_ready_out), 0);
        @(posedge clk_in);
        #1;
        cfg_valid_in = 1'b0;
        step_in      = 1'b0;
        check("t5_overrun_set", 32'(overrun_out), 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) begin
                pulses++;
                smp = 32'(sample_out);
            end
        end
        check("t5_one_pulse", 32'(pulses), 1);
        check("t5_sample", smp, 0);
        strobe(smp, lat, bcyc, found);
        check("t5_cfg_unchanged", smp, 0);
        check("t5_overrun_sticky", 32'(overrun_out), 1);

        // 6: asynchronous reset in mid-sweep
        cfg_write(0, 1'b1, 32'h0, 1'b1, 32'h4000_0000);
        strobe(smp, lat, bcyc, found);
        check("t6_pre_sample", smp, 255);
        @(negedge clk_in);
        step_in = 1'b1;
        @(posedge clk_in);
        #1 step_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("t6_busy_before", 32'(busy_out), 1);
        #2 rst_in = 1'b0;
        #1;
        check("t6_rst_sample", 32'(sample_out), 0);
        check("t6_rst_busy", 32'(busy_out), 0);
        check("t6_rst_ready", 32'(cfg_ready_out), 1);
        check("t6_rst_overrun", 32'(overrun_out), 0);
        check("t6_rst_valid", 32'(sample_valid_out), 0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) pulses++;
        end
        check("t6_no_pulse", 32'(pulses), 0);
        strobe(smp, lat, bcyc, found);
        check("t6_found", 32'(found), 1);
        check("t6_cleared", smp, 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
